hub75_scan_ctrl: RTL and testbench

Parametrised HUB75 panel scan controller: the successor to the fixed 3-module, 4-row, always-full-brightness driver. Row-address width, chain length, clock divider, row period and brightness are all configurable. It reads pixel data from an external frame store through a column/row fetch port instead of holding hard-coded constants, and runs an explicit per-row shift/latch/show/blank state machine. It sits between the frame buffer (or the traffic-light pattern generator) and the panel connector pins.

---
 rtl/hub75_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_ctrl.sv
// HUB75 panel scan controller.
// Divides clk into scan ticks, fetches each row's pixels from an external frame
// store, shifts them into the chained panels, latches them, then shows the row
// for a clamped brightness time before blanking and moving to the next row.
module hub75_scan_ctrl #(
  parameter int NUM_MOD    = 3,
  parameter int PIX_MOD    = 64,
  parameter int ROW_BITS   = 2,
  parameter int CLK_DIV    = 10,
  parameter int ROW_PERIOD = 5000,
  parameter int BRIGHT_W   = 12,
  localparam int NUM_BITS  = NUM_MOD * PIX_MOD,
  localparam int COL_W     = $clog2(NUM_BITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic                pix_rd,
  output logic [COL_W-1:0]    pix_col,
  output logic [ROW_BITS-1:0] pix_row,
  input  logic [5:0]          pix_data,
  output logic                R1,
  output logic                G1,
  output logic                B1,
  output logic                R2,
  output logic                G2,
  output logic                B2,
  output logic [ROW_BITS-1:0] A_ADDR,
  output logic                CLK_M,
  output logic                LAT,
  output logic                OE,
  output logic                frame_start
);

  localparam int unsigned MAX_ON = ROW_PERIOD - 2 * NUM_BITS - 2;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int CW    = $clog2(ROW_PERIOD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH,
    S_SHOW,
    S_BLANK
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [CW-1:0]       slot;       // tick index within the current row
  logic [CW-1:0]       on_ticks;   // brightness captured at LATCH
  logic [CW-1:0]       on_clamped;
  logic [CW-1:0]       show_last;
  logic [ROW_BITS-1:0] row;

  // Tick divider: one tick every CLK_DIV+1 clks
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_W'(CLK_DIV)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Tick decode, brightness clamp and last SHOW slot of the row
  always_comb begin
    tick       = (div_cnt == DIV_W'(CLK_DIV));
    on_clamped = CW'(brightness);
    if (32'(brightness) > MAX_ON) begin
      on_clamped = CW'(MAX_ON);
    end
    show_last  = CW'(2 * NUM_BITS) + on_ticks;
  end

  // Row scan FSM; slot counts ticks since the start of SHIFT so the four
  // phases always add up to exactly ROW_PERIOD ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      slot        <= '0;
      on_ticks    <= '0;
      row         <= '0;
      A_ADDR      <= '0;
      {R1, G1, B1, R2, G2, B2} <= '0;
      CLK_M       <= 1'b0;
      LAT         <= 1'b0;
      OE          <= 1'b1;
      pix_rd      <= 1'b0;
      pix_col     <= '0;
      pix_row     <= '0;
      frame_start <= 1'b0;
    end else begin
      pix_rd      <= 1'b0;
      frame_start <= 1'b0;
      if (pix_rd) begin
        {R1, G1, B1, R2, G2, B2} <= pix_data;
      end
      if (tick) begin
        case (state)
          S_IDLE: begin
            state <= S_SHIFT;
            slot  <= '0;
          end
          S_SHIFT: begin
            if (!slot[0]) begin
              pix_rd      <= 1'b1;
              pix_col     <= COL_W'(slot >> 1);
              pix_row     <= row;
              frame_start <= (row == '0) && (slot == '0);
              CLK_M       <= 1'b0;
            end else begin
              CLK_M       <= 1'b1;
            end
            if (slot == CW'(2 * NUM_BITS - 1)) begin
              state <= S_LATCH;
            end
            slot <= slot + CW'(1);
          end
          S_LATCH: begin
            CLK_M    <= 1'b0;
            LAT      <= 1'b1;
            OE       <= 1'b1;
            A_ADDR   <= row;
            on_ticks <= on_clamped;
            state    <= (on_clamped != '0) ? S_SHOW : S_BLANK;
            slot     <= slot + CW'(1);
          end
          S_SHOW: begin
            LAT <= 1'b0;
            OE  <= 1'b0;
            if (slot == show_last) begin
              state <= S_BLANK;
            end
            slot <= slot + CW'(1);
          end
          S_BLANK: begin
            LAT <= 1'b0;
            OE  <= 1'b1;
            if (slot == CW'(ROW_PERIOD - 1)) begin
              state <= S_SHIFT;
              slot  <= '0;
              row   <= row + 1'b1;
            end else begin
              slot <= slot + CW'(1);
            end
          end
          default: begin
            state <= S_IDLE;
            slot  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed testbench for hub75_scan_ctrl with a 4-column, 4-row, 20-tick row setup.
module tb_hub75_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] brightness = '0;
  logic        pix_rd;
  logic [1:0]  pix_col;
  logic [1:0]  pix_row;
  logic [5:0]  pix_data;
  logic        R1, G1, B1, R2, G2, B2;
  logic [1:0]  A_ADDR;
  logic        CLK_M, LAT, OE, frame_start;

  logic [5:0]  pat [4];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  initial begin
    pat[0] = 6'b100001;
    pat[1] = 6'b010010;
    pat[2] = 6'b001100;
    pat[3] = 6'b111111;
  end

  // Frame store model: combinational read by column
  always_comb pix_data = pat[pix_col];

  hub75_scan_ctrl #(
    .NUM_MOD(1), .PIX_MOD(4), .ROW_BITS(2), .CLK_DIV(2),
    .ROW_PERIOD(20), .BRIGHT_W(12)
  ) dut (
    .clk(clk), .rst(rst), .brightness(brightness),
    .pix_rd(pix_rd), .pix_col(pix_col), .pix_row(pix_row), .pix_data(pix_data),
    .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
    .A_ADDR(A_ADDR), .CLK_M(CLK_M), .LAT(LAT), .OE(OE), .frame_start(frame_start)
  );

  task automatic wait_lat_rise(output bit ok);
    bit prev;
    prev = LAT;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (LAT && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = LAT;
    end
  endtask

  task automatic count_oe_low(output int n);
    n = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (OE == 1'b0) n++;
    end
  endtask

  task automatic test_reset;
    int k;
    rst = 1'b1;
    brightness = '0;
    repeat (5) @(negedge clk);
    checks++;
    if ({OE, LAT, CLK_M, pix_rd, frame_start} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl got %b want 10000", {OE, LAT, CLK_M, pix_rd, frame_start});
    end
    checks++;
    if ({R1, G1, B1, R2, G2, B2, A_ADDR, pix_col, pix_row} !== 12'h000) begin
      failures++;
      $display("FAIL reset_data got %h want 000", {R1, G1, B1, R2, G2, B2, A_ADDR, pix_col, pix_row});
    end
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      k++;
      if (pix_rd) break;
    end
    checks++;
    if (k != 6) begin
      failures++;
      $display("FAIL first_pix_rd got %0d clks want 6", k);
    end
    checks++;
    if ({frame_start, pix_col, pix_row} !== 5'b10000) begin
      failures++;
      $display("FAIL first_fetch got %b want 10000", {frame_start, pix_col, pix_row});
    end
  endtask

  task automatic test_datapath;
    int  rises, lat_clks;
    bit  prev, seen;
    rises = 0; lat_clks = 0; seen = 1'b0; prev = CLK_M;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (CLK_M && !prev) begin
        if (rises < 4) begin
          checks++;
          if ({R1, G1, B1, R2, G2, B2} !== pat[rises]) begin
            failures++;
            $display("FAIL shift_data%0d got %b want %b", rises, {R1, G1, B1, R2, G2, B2}, pat[rises]);
          end
        end
        rises++;
      end
      prev = CLK_M;
      if (LAT) begin
        if (!seen) begin
          checks++;
          if ({A_ADDR, CLK_M, OE} !== 4'b0001) begin
            failures++;
            $display("FAIL latch_pins got %b want 0001", {A_ADDR, CLK_M, OE});
          end
        end
        seen = 1'b1;
        lat_clks++;
      end else if (seen) begin
        break;
      end
    end
    checks++;
    if (rises != 4) begin
      failures++;
      $display("FAIL clkm_rises got %0d want 4", rises);
    end
    checks++;
    if (lat_clks != 3) begin
      failures++;
      $display("FAIL lat_width got %0d want 3", lat_clks);
    end
  endtask

  task automatic test_brightness;
    int  bval [3];
    int  want [3];
    int  n;
    bit  ok;
    bval[0] = 5;    want[0] = 15;
    bval[1] = 0;    want[1] = 0;
    bval[2] = 4095; want[2] = 30;
    for (int t = 0; t < 3; t++) begin
      brightness = 12'(bval[t]);
      wait_lat_rise(ok);
      count_oe_low(n);
      checks++;
      if (!ok || n != want[t]) begin
        failures++;
        $display("FAIL bright_%0d got ok=%0d low=%0d want low=%0d", bval[t], ok, n, want[t]);
      end
    end
  endtask

  task automatic test_scan_wrap;
    int lat_n, fs;
    bit prev;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    brightness = 12'd1;
    rst = 1'b0;
    lat_n = 0; fs = 0; prev = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_start) fs++;
      if (pix_rd && pix_col == 2'd0) begin
        checks++;
        if (pix_row !== 2'(lat_n % 4)) begin
          failures++;
          $display("FAIL pix_row_%0d got %0d want %0d", lat_n, pix_row, lat_n % 4);
        end
      end
      if (LAT && !prev) begin
        checks++;
        if (A_ADDR !== 2'(lat_n % 4)) begin
          failures++;
          $display("FAIL a_addr_%0d got %0d want %0d", lat_n, A_ADDR, lat_n % 4);
        end
        lat_n++;
        if (lat_n == 5) break;
      end
      prev = LAT;
    end
    checks++;
    if (lat_n != 5) begin
      failures++;
      $display("FAIL rows_seen got %0d want 5", lat_n);
    end
    checks++;
    if (fs != 2) begin
      failures++;
      $display("FAIL frame_starts got %0d want 2", fs);
    end
  endtask

  task automatic test_mid_row_reset;
    int  k, rises;
    bit  prev, found, got_lat;
    brightness = 12'd5;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (OE == 1'b0 && A_ADDR != 2'd0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_show got none want OE low");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({OE, LAT, CLK_M, pix_rd, A_ADDR} !== 6'b100000) begin
      failures++;
      $display("FAIL midrst_pins got %b want 100000", {OE, LAT, CLK_M, pix_rd, A_ADDR});
    end
    rst = 1'b0;
    k = 0; rises = 0; prev = CLK_M; found = 1'b0; got_lat = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      k++;
      if (CLK_M && !prev) rises++;
      prev = CLK_M;
      if (pix_rd && !found) begin
        found = 1'b1;
        checks++;
        if ({k[3:0], pix_row, frame_start} !== {4'd6, 2'd0, 1'b1}) begin
          failures++;
          $display("FAIL restart_fetch got k=%0d row=%0d fs=%0d want 6 0 1", k, pix_row, frame_start);
        end
      end
      if (LAT) begin
        got_lat = 1'b1;
        break;
      end
    end
    checks++;
    if (!got_lat || rises != 4 || k != 30 || A_ADDR !== 2'd0) begin
      failures++;
      $display("FAIL restart_latch got lat=%0d rises=%0d k=%0d addr=%0d want 1 4 30 0",
               got_lat, rises, k, A_ADDR);
    end
  endtask

  task automatic test_brightness_change;
    int n;
    bit ok;
    brightness = 12'd2;
    wait_lat_rise(ok);
    n = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (OE == 1'b0) begin
        n++;
        brightness = 12'd8;
      end
    end
    checks++;
    if (!ok || n != 6) begin
      failures++;
      $display("FAIL bright_hold got ok=%0d low=%0d want low=6", ok, n);
    end
    wait_lat_rise(ok);
    count_oe_low(n);
    checks++;
    if (!ok || n != 24) begin
      failures++;
      $display("FAIL bright_next got ok=%0d low=%0d want low=24", ok, n);
    end
  endtask

  initial begin
    test_reset();
    test_datapath();
    test_brightness();
    test_scan_wrap();
    test_mid_row_reset();
    test_brightness_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
